line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter ByteOffsetBits, default 4, meaning log2 of bytes per line; LineSize = 8*2**ByteOffsetBits.
REQ-002 SHALL have parameter NrLines, default 4096, meaning line count of backing store, power of two.
REQ-003 SHALL have parameter Latency, default 10, meaning cycles from request accept to valid; legal range 1..255.
REQ-004 SHALL have parameter InitFile, default "", meaning hex line-init file; empty means no initialisation.
REQ-005 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port addr_i  in  32  byte address of requested line.
REQ-008 SHALL have port read_en_i  in  1  level-held line-read request.
REQ-009 SHALL have port read_valid_o  out  1  one-cycle pulse: read_data_o valid.
REQ-010 SHALL have port read_data_o  out  LineSize  returned line.
REQ-011 SHALL have port write_en_i  in  1  level-held line-write request.
REQ-012 SHALL have port write_data_i  in  LineSize  line to store.
REQ-013 SHALL have port write_valid_o  out  1  one-cycle pulse: write committed.
REQ-014 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE, WRITE_WAIT, READ_WAIT, COOLDOWN.
REQ-016 In IDLE, write_en_i=1 SHALL be accepted at that edge: capture index and write_data_i, load counter with Latency-1, go WRITE_WAIT.
REQ-017 In IDLE with write_en_i=0 and read_en_i=1 SHALL accept read likewise, go READ_WAIT; simultaneous read+write: write wins, read served on a later accept.
REQ-018 Line index SHALL be addr_i[ByteOffsetBits +: log2(NrLines)]; upper and byte-offset bits ignored (addresses wrap modulo NrLines lines).
REQ-019 Counter SHALL decrement each cycle in WAIT states; at zero WAIT SHALL go COOLDOWN.
REQ-020 Leaving WRITE_WAIT SHALL commit captured data to the array and pulse write_valid_o for exactly one cycle, Latency cycles after accept edge.
REQ-021 Leaving READ_WAIT SHALL pulse read_valid_o for one cycle, Latency cycles after accept edge, with read_data_o = stored line.
REQ-022 read_data_o SHALL hold its value until the next read completion.
REQ-023 COOLDOWN SHALL last one cycle, ignore both enables, then return IDLE; requester drops enable the cycle after valid.
REQ-024 Enables dropped during WAIT SHALL NOT abort: write still commits, read still pulses valid.
REQ-025 addr_i/write_data_i changes after accept SHALL have no effect on the in-flight operation.
REQ-026 Write then read of same line SHALL return the written data (no stale read).

Reset
REQ-027 rst_i=1 at an edge SHALL force IDLE, counter 0, read_valid_o=0, write_valid_o=0, busy_o=0, read_data_o=0.
REQ-028 Reset mid-WRITE_WAIT SHALL discard the write (array unchanged); mid-READ_WAIT SHALL suppress read_valid_o.
REQ-029 Array contents SHALL NOT be cleared by reset.

Structure
REQ-030 Package cache_mem_pkg SHALL hold the FSM state enum and LineSize/index-width helper functions.
REQ-031 Backing store SHALL be sub-module line_mem_array (single-port synchronous RAM, NrLines x LineSize, optional $readmemh of InitFile).
REQ-032 FSM, counter and capture registers SHALL reside in line_mem_responder.

Verification
REQ-033 Reset, write_en_i=1, addr 0x00000010, data 0x...DEADBEEF (word 0) -> write_valid_o pulses one cycle exactly 10 cycles after accept; busy_o high 11 cycles.
REQ-034 Read addr 0x00000010 afterwards -> read_valid_o after 10 cycles, read_data_o word 0 = 0xDEADBEEF.
REQ-035 read_en_i and write_en_i both high in IDLE, addr 0x18 -> write_valid_o first; read served after COOLDOWN, returning the new line.
REQ-036 Write 0x12345678 to addr 0x00010010 (NrLines=4096) -> read of 0x00000010 returns 0x12345678 (index wrap).
REQ-037 rst_i pulsed 5 cycles into a write to 0x20 -> no write_valid_o; subsequent read of 0x20 returns prior contents.
REQ-038 Enables held high through valid and COOLDOWN -> exactly one valid pulse per accept, next accept at COOLDOWN+1.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types and sizing helpers for the line memory responder.
//   state_e     : responder FSM states
//   CountBits   : width of the latency down-counter (Latency <= 255)
//   line_size() : bits per line for a given log2(bytes per line)
//   index_bits(): line-index width for a power-of-two line count
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WAIT,
        READ_WAIT,
        COOLDOWN
    } state_e;

    localparam int unsigned CountBits = 8;

    function automatic int unsigned line_size(input int unsigned byte_offset_bits);
        return 8 * (32'd1 << byte_offset_bits);
    endfunction

    function automatic int unsigned index_bits(input int unsigned nr_lines);
        return (nr_lines > 1) ? $clog2(nr_lines) : 1;
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response bundle of the line memory responder.
//   addr, read_en, write_en, write_data : requester -> responder
//   read_valid, read_data, write_valid, busy : responder -> requester
// master = requester side, slave = responder side.
interface line_mem_responder_if #(
    parameter int unsigned LineSize = 128
);
    logic [31:0]         addr;
    logic                read_en;
    logic                write_en;
    logic [LineSize-1:0] write_data;
    logic                read_valid;
    logic [LineSize-1:0] read_data;
    logic                write_valid;
    logic                busy;

    modport master (
        output addr, read_en, write_en, write_data,
        input  read_valid, read_data, write_valid, busy
    );

    modport slave (
        input  addr, read_en, write_en, write_data,
        output read_valid, read_data, write_valid, busy
    );
endinterface

// File: rtl/line_mem_array.sv
// Single-port synchronous line RAM (Depth x Width), read-first, registered
// read data.
//   i_clk   : clock
//   i_we    : write strobe
//   i_addr  : line index
//   i_wdata : line to write
//   o_rdata : line read at the previous edge
module line_mem_array #(
  parameter int unsigned Width    = 128,
  parameter int unsigned Depth    = 4096,
  parameter int unsigned AddrBits = 12,
  parameter string       InitFile = ""
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AddrBits-1:0] i_addr,
  input  logic [Width-1:0]    i_wdata,
  output logic [Width-1:0]    o_rdata
);
  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder: accepts one level-held read or write
// request in IDLE, completes it Latency cycles later with a one-cycle valid
// pulse, then spends one COOLDOWN cycle before accepting again.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   addr_i                : byte address (line index taken from it)
//   read_en_i             : read request     read_valid_o / read_data_o : result
//   write_en_i            : write request    write_data_i : line to store
//   write_valid_o         : write committed  busy_o : not in IDLE
module line_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned ByteOffsetBits = 4,
    parameter int unsigned NrLines        = 4096,
    parameter int unsigned Latency        = 10,
    parameter string       InitFile       = ""
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [31:0]                          addr_i,
    input  logic                                 read_en_i,
    output logic                                 read_valid_o,
    output logic [line_size(ByteOffsetBits)-1:0] read_data_o,
    input  logic                                 write_en_i,
    input  logic [line_size(ByteOffsetBits)-1:0] write_data_i,
    output logic                                 write_valid_o,
    output logic                                 busy_o
);
    localparam int unsigned LineSize = line_size(ByteOffsetBits);
    localparam int unsigned IdxBits  = index_bits(NrLines);
    localparam logic [CountBits-1:0] CountInit = CountBits'(Latency - 1);

    state_e               r_state;
    logic [CountBits-1:0] r_count;
    logic [IdxBits-1:0]   r_index;
    logic [LineSize-1:0]  r_wdata;
    logic [LineSize-1:0]  r_read_data;
    logic                 r_read_valid;
    logic                 r_write_valid;
    logic                 r_busy;

    logic [IdxBits-1:0]   w_index;
    logic [IdxBits-1:0]   w_mem_addr;
    logic                 w_mem_we;
    logic [LineSize-1:0]  w_mem_rdata;
    logic                 w_unused_addr;

    // Upper and byte-offset address bits are deliberately ignored.
    assign w_index       = addr_i[ByteOffsetBits +: IdxBits];
    assign w_unused_addr = ^addr_i;

    // The RAM read port follows the live address in IDLE so that a Latency=1
    // read already has its data registered at the completion edge; afterwards
    // it keeps re-reading the captured line.
    assign w_mem_addr = (r_state == IDLE) ? w_index : r_index;
    // Commit happens on the edge that leaves WRITE_WAIT; reset suppresses it.
    assign w_mem_we   = (r_state == WRITE_WAIT) && (r_count == '0) && !rst_i;

    line_mem_array #(
        .Width   (LineSize),
        .Depth   (NrLines),
        .AddrBits(IdxBits),
        .InitFile(InitFile)
    ) u_array (
        .i_clk  (clk_i),
        .i_we   (w_mem_we),
        .i_addr (w_mem_addr),
        .i_wdata(r_wdata),
        .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_index       <= '0;
            r_wdata       <= '0;
            r_read_data   <= '0;
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_read_valid  <= 1'b0;
            r_write_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (write_en_i) begin
                        r_index <= w_index;
                        r_wdata <= write_data_i;
                        r_count <= CountInit;
                        r_busy  <= 1'b1;
                        r_state <= WRITE_WAIT;
                    end else if (read_en_i) begin
                        r_index <= w_index;
                        r_count <= CountInit;
                        r_busy  <= 1'b1;
                        r_state <= READ_WAIT;
                    end
                end
                WRITE_WAIT: begin
                    if (r_count == '0) begin
                        r_write_valid <= 1'b1;
                        r_state       <= COOLDOWN;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (r_count == '0) begin
                        r_read_valid <= 1'b1;
                        r_read_data  <= w_mem_rdata;
                        r_state      <= COOLDOWN;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                COOLDOWN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_valid_o  = r_read_valid;
    assign read_data_o   = r_read_data;
    assign write_valid_o = r_write_valid;
    assign busy_o        = r_busy;
endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder (default geometry, Latency 10).
// Expected completions are queued when a request is driven and popped by a
// negedge monitor when the DUT pulses a valid.
module tb_line_mem_responder;
    localparam int unsigned LAT = 10;
    localparam int unsigned LW  = 128;

    localparam logic [LW-1:0] D0 = 128'h0011_2233_4455_6677_8899_AABB_DEAD_BEEF;
    localparam logic [LW-1:0] D1 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_AAAA;
    localparam logic [LW-1:0] D2 = 128'h0BAD_C0DE_0000_0000_FFFF_FFFF_1234_5678;
    localparam logic [LW-1:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [LW-1:0] D4 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [LW-1:0] D5 = 128'hBADB_ADBA_DBAD_BADB_ADBA_DBAD_BADB_ADBA;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_responder_if #(.LineSize(LW)) bus ();

    line_mem_responder #(
        .ByteOffsetBits(4),
        .NrLines       (4096),
        .Latency       (LAT),
        .InitFile      ("")
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (bus.addr),
        .read_en_i    (bus.read_en),
        .read_valid_o (bus.read_valid),
        .read_data_o  (bus.read_data),
        .write_en_i   (bus.write_en),
        .write_data_i (bus.write_data),
        .write_valid_o(bus.write_valid),
        .busy_o       (bus.busy)
    );

    typedef struct {
        int unsigned   cyc;
        logic [LW-1:0] data;
    } exp_t;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rexp;
    } vec_t;

    exp_t wq[$];
    exp_t rq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.write_valid === 1'b1) begin
            if (wq.size() == 0) begin
                check("spurious write_valid", LW'(bus.write_valid), '0);
            end else begin
                e = wq.pop_front();
                check("write_valid cycle", LW'(cyc), LW'(e.cyc));
            end
        end
        if (bus.read_valid === 1'b1) begin
            if (rq.size() == 0) begin
                check("spurious read_valid", LW'(bus.read_valid), '0);
            end else begin
                e = rq.pop_front();
                check("read_valid cycle", LW'(cyc), LW'(e.cyc));
                check("read_data", bus.read_data, e.data);
            end
        end
    end

    task automatic drain_check(input string name);
        check({name, " outstanding"}, LW'(wq.size() + rq.size()), '0);
        wq.delete();
        rq.delete();
    endtask

    // Drive one table entry. Accept edge is the posedge after enables rise.
    // In-flight address/data are scrambled after accept; for read+write the
    // write enable is dropped after write_valid so the read is served next.
    task automatic run_op(input vec_t v, input string name);
        int unsigned a;
        int unsigned busy_cnt;
        @(posedge clk); #1;
        bus.addr       = v.addr;
        bus.write_data = v.wdata;
        bus.write_en   = v.wr;
        bus.read_en    = v.rd;
        a = cyc + 1;
        if (v.wr) wq.push_back('{a + LAT, v.wdata});
        if (v.rd) rq.push_back('{(v.wr ? a + 2 * LAT + 2 : a + LAT), v.rexp});
        busy_cnt = 0;
        for (int i = 0; i < int'(LAT) + 3; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (i == 1) begin
                bus.addr       = ~v.addr;
                bus.write_data = ~v.wdata;
            end
            if (v.wr && v.rd && i == int'(LAT) + 1) begin
                bus.write_en = 1'b0;
                bus.addr     = v.addr;
            end
        end
        check({name, " busy cycles"}, LW'(busy_cnt), LW'(LAT + 1));
        if (v.wr && v.rd) begin
            for (int j = 0; j < int'(LAT) + 2; j++) @(negedge clk);
        end
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        drain_check(name);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, D0, '0};  // write line 1
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, '0, D0};  // read back
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0018, D1, D1};  // write wins, then read
        vecs[3] = '{1'b1, 1'b0, 32'h0001_0010, D2, '0};  // wraps onto line 1
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, '0, D2};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, D3, '0};  // line 2
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0025, '0, D3};  // byte offset ignored
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFF0, D4, '0};  // top line 0xFFF
        vecs[8] = '{1'b0, 1'b1, 32'h0000_FFF0, '0, D4};
        vecs[9] = '{1'b0, 1'b1, 32'h0000_0020, '0, D3};

        rst            = 1'b1;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", LW'(bus.busy), '0);
        check("reset write_valid", LW'(bus.write_valid), '0);
        check("reset read_valid", LW'(bus.read_valid), '0);
        check("reset read_data", bus.read_data, '0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Read enable held across two completions: one pulse per accept,
        // second accept on the edge after COOLDOWN.
        begin
            int unsigned a;
            @(posedge clk); #1;
            bus.addr    = 32'h0000_0020;
            bus.read_en = 1'b1;
            a = cyc + 1;
            rq.push_back('{a + LAT, D3});
            rq.push_back('{a + 2 * LAT + 2, D3});
            for (int i = 0; i < 2 * int'(LAT) + 5; i++) @(negedge clk);
            bus.read_en = 1'b0;
            drain_check("held read");
        end

        // Reset five cycles into a write: write discarded, read_data cleared.
        @(posedge clk); #1;
        bus.addr       = 32'h0000_0020;
        bus.write_data = D5;
        bus.write_en   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("read_data held", bus.read_data, D3);
        check("busy mid write", LW'(bus.busy), LW'(1));
        rst          = 1'b1;
        bus.write_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset busy", LW'(bus.busy), '0);
        check("midreset write_valid", LW'(bus.write_valid), '0);
        check("midreset read_data", bus.read_data, '0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        run_op('{1'b0, 1'b1, 32'h0000_0020, '0, D3}, "read after abort");

        repeat (4) @(negedge clk);
        drain_check("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
